// File: rtl/dram_cmd_decoder.sv
// rtl/dram_cmd_decoder.sv - behavioural DRAM command/address receiver and decoder
//
// Samples the DRAM command pins on every rising edge of clk1 and, one cycle
// later, presents the decoded command, bank, row and column. Captures MR0..MR3,
// tracks per-bank open state and open row, drives read/write data-window
// strobes and latches the first protocol error.
//
// Ports:
//   clk1, rst                      clock, asynchronous active-high reset
//   cke, cs_n, ras_n, cas_n, we_n  command pins
//   ba, addr                       bank / address pins
//   o_cmd_valid, o_cmd             decoded command pulse and code
//   o_ba, o_row, o_col             bank, row (ACT, and open row on RD/WR), column
//   o_mr0..o_mr3                   captured mode registers
//   o_bank_open                    one bit per bank, 1 = row open
//   o_rd_window, o_wr_window       data-burst strobes
//   o_err, o_err_code              sticky first protocol error
//
// Build option: DRAM_CMD_DEC_TIMING_CHECK_EN adds the tRCD/tRP counters and
// error codes 3/4; without it those codes are never raised.

module dram_cmd_decoder #(
  parameter int ADDR_BITS = 14,
  parameter int BA_BITS   = 3,
  parameter int COL_BITS  = 9,
  parameter int AP_BIT    = 9,
  parameter int TRCD      = 4,
  parameter int TRP       = 4,
  parameter int RL        = 6,
  parameter int WL        = 5,
  parameter int BURST_CYC = 4
) (
  input  logic                       clk1,
  input  logic                       rst,
  input  logic                       cke,
  input  logic                       cs_n,
  input  logic                       ras_n,
  input  logic                       cas_n,
  input  logic                       we_n,
  input  logic [BA_BITS-1:0]         ba,
  input  logic [ADDR_BITS-1:0]       addr,
  output logic                       o_cmd_valid,
  output logic [3:0]                 o_cmd,
  output logic [BA_BITS-1:0]         o_ba,
  output logic [ADDR_BITS-1:0]       o_row,
  output logic [COL_BITS-1:0]        o_col,
  output logic [15:0]                o_mr0,
  output logic [15:0]                o_mr1,
  output logic [15:0]                o_mr2,
  output logic [15:0]                o_mr3,
  output logic [(2**BA_BITS)-1:0]    o_bank_open,
  output logic                       o_rd_window,
  output logic                       o_wr_window,
  output logic                       o_err,
  output logic [2:0]                 o_err_code
);
  localparam int NUM_BANKS = 2 ** BA_BITS;
  localparam int BCW       = $clog2(BURST_CYC + 1);

  localparam logic [3:0] CMD_NOP  = 4'd0,  CMD_MRS  = 4'd1,  CMD_ZQCL = 4'd2,
                         CMD_ZQCS = 4'd3,  CMD_ACT  = 4'd4,  CMD_RD   = 4'd5,
                         CMD_WR   = 4'd6,  CMD_RDA  = 4'd7,  CMD_WRA  = 4'd8,
                         CMD_PRE  = 4'd9,  CMD_PREA = 4'd10, CMD_REF  = 4'd11;

  // Pin decode
  logic [3:0] cmd_d;
  logic is_act, is_rd, is_wr, is_rdfam, is_pre, is_prea, is_ap, is_mrs, is_mode;

  always_comb begin
    cmd_d = CMD_NOP;
    if (cke && !cs_n) begin
      case ({ras_n, cas_n, we_n})
        3'b000:  cmd_d = CMD_MRS;
        3'b001:  cmd_d = CMD_REF;
        3'b010:  cmd_d = addr[10] ? CMD_PREA : CMD_PRE;
        3'b011:  cmd_d = CMD_ACT;
        3'b100:  cmd_d = addr[AP_BIT] ? CMD_WRA : CMD_WR;
        3'b101:  cmd_d = addr[AP_BIT] ? CMD_RDA : CMD_RD;
        3'b110:  cmd_d = addr[10] ? CMD_ZQCL : CMD_ZQCS;
        default: cmd_d = CMD_NOP;
      endcase
    end
    is_act   = (cmd_d == CMD_ACT);
    is_rd    = (cmd_d == CMD_RD)  || (cmd_d == CMD_RDA);
    is_wr    = (cmd_d == CMD_WR)  || (cmd_d == CMD_WRA);
    is_rdfam = is_rd || is_wr;
    is_pre   = (cmd_d == CMD_PRE);
    is_prea  = (cmd_d == CMD_PREA);
    is_ap    = (cmd_d == CMD_RDA) || (cmd_d == CMD_WRA);
    is_mrs   = (cmd_d == CMD_MRS);
    is_mode  = is_mrs || (cmd_d == CMD_REF) || (cmd_d == CMD_ZQCL) || (cmd_d == CMD_ZQCS);
  end

  // Bank timing counters
  logic trcd_busy, trp_busy;

`ifdef DRAM_CMD_DEC_TIMING_CHECK_EN
  localparam int TCW = $clog2(((TRCD > TRP) ? TRCD : TRP) + 1);
  logic [TCW-1:0] trcd_q [NUM_BANKS];
  logic [TCW-1:0] trcd_d [NUM_BANKS];
  logic [TCW-1:0] trp_q  [NUM_BANKS];
  logic [TCW-1:0] trp_d  [NUM_BANKS];

  // Loaded with T-1 so that a command issued T or more cycles later sees zero.
  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      trcd_d[b] = (trcd_q[b] != '0) ? trcd_q[b] - TCW'(1) : '0;
      trp_d[b]  = (trp_q[b]  != '0) ? trp_q[b]  - TCW'(1) : '0;
      if (is_act && (ba == BA_BITS'(b)))
        trcd_d[b] = TCW'(TRCD - 1);
      if (is_prea || ((is_pre || is_ap) && (ba == BA_BITS'(b))))
        trp_d[b] = TCW'(TRP - 1);
    end
    trcd_busy = (trcd_q[ba] != '0);
    trp_busy  = (trp_q[ba]  != '0);
  end

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        trcd_q[b] <= '0;
        trp_q[b]  <= '0;
      end
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        trcd_q[b] <= trcd_d[b];
        trp_q[b]  <= trp_d[b];
      end
    end
  end
`else
  assign trcd_busy = 1'b0;
  assign trp_busy  = 1'b0;
`endif

  // Bank state, mode registers, data windows, error
  logic [NUM_BANKS-1:0] bank_open_q, bank_open_d;
  logic [ADDR_BITS-1:0] open_row_q [NUM_BANKS];
  logic [ADDR_BITS-1:0] open_row_d [NUM_BANKS];
  logic [15:0]          mr_q [4];
  logic [15:0]          mr_d [4];
  logic [RL-1:0]        rd_pipe_q, rd_pipe_d;
  logic [WL-1:0]        wr_pipe_q, wr_pipe_d;
  logic [BCW-1:0]       rd_burst_q, rd_burst_d, wr_burst_q, wr_burst_d;
  logic                 err_q, err_d;
  logic [2:0]           err_code_q, err_code_d, err_new;
  logic                 cmd_valid_q, cmd_valid_d;
  logic [3:0]           cmd_q;
  logic [BA_BITS-1:0]   ba_q, ba_d;
  logic [ADDR_BITS-1:0] row_q, row_d;
  logic [COL_BITS-1:0]  col_q, col_d;

  always_comb begin
    bank_open_d = bank_open_q;
    open_row_d  = open_row_q;
    if (is_act) begin
      bank_open_d[ba] = 1'b1;
      open_row_d[ba]  = addr;
    end
    if (is_pre || is_ap) bank_open_d[ba] = 1'b0;
    if (is_prea)         bank_open_d     = '0;

    mr_d = mr_q;
    if (is_mrs) mr_d[ba[1:0]] = 16'(addr);

    // Token reaches the pipe tail RL-1 edges after the sample; the burst
    // counter loads on the next edge, so the window opens RL edges after it.
    // A reload while a burst is still running simply extends it (no gap).
    rd_pipe_d  = {rd_pipe_q[RL-2:0], is_rd};
    wr_pipe_d  = {wr_pipe_q[WL-2:0], is_wr};
    rd_burst_d = rd_pipe_q[RL-1] ? BCW'(BURST_CYC)
               : ((rd_burst_q != '0) ? rd_burst_q - BCW'(1) : '0);
    wr_burst_d = wr_pipe_q[WL-1] ? BCW'(BURST_CYC)
               : ((wr_burst_q != '0) ? wr_burst_q - BCW'(1) : '0);

    // Later assignments override, so the lowest code wins.
    err_new = 3'd0;
    if (is_mode && (|bank_open_q))          err_new = 3'd5;
    if (is_act && trp_busy)                 err_new = 3'd4;
    if (is_rdfam && trcd_busy)              err_new = 3'd3;
    if (is_rdfam && !bank_open_q[ba])       err_new = 3'd2;
    if (is_act && bank_open_q[ba])          err_new = 3'd1;
    err_d      = err_q || (err_new != 3'd0);
    err_code_d = err_q ? err_code_q : err_new;

    cmd_valid_d = (cmd_d != CMD_NOP);
    ba_d        = cmd_valid_d ? ba : '0;
    row_d       = is_act ? addr : (is_rdfam ? open_row_q[ba] : '0);
    col_d       = is_rdfam ? addr[COL_BITS-1:0] : '0;
  end

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      bank_open_q <= '0;
      for (int b = 0; b < NUM_BANKS; b++) open_row_q[b] <= '0;
      for (int m = 0; m < 4; m++) mr_q[m] <= '0;
      rd_pipe_q   <= '0;
      wr_pipe_q   <= '0;
      rd_burst_q  <= '0;
      wr_burst_q  <= '0;
      err_q       <= 1'b0;
      err_code_q  <= '0;
      cmd_valid_q <= 1'b0;
      cmd_q       <= CMD_NOP;
      ba_q        <= '0;
      row_q       <= '0;
      col_q       <= '0;
    end else begin
      bank_open_q <= bank_open_d;
      open_row_q  <= open_row_d;
      mr_q        <= mr_d;
      rd_pipe_q   <= rd_pipe_d;
      wr_pipe_q   <= wr_pipe_d;
      rd_burst_q  <= rd_burst_d;
      wr_burst_q  <= wr_burst_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_q       <= cmd_d;
      ba_q        <= ba_d;
      row_q       <= row_d;
      col_q       <= col_d;
    end
  end

  assign o_cmd_valid = cmd_valid_q;
  assign o_cmd       = cmd_q;
  assign o_ba        = ba_q;
  assign o_row       = row_q;
  assign o_col       = col_q;
  assign o_mr0       = mr_q[0];
  assign o_mr1       = mr_q[1];
  assign o_mr2       = mr_q[2];
  assign o_mr3       = mr_q[3];
  assign o_bank_open = bank_open_q;
  assign o_rd_window = (rd_burst_q != '0);
  assign o_wr_window = (wr_burst_q != '0);
  assign o_err       = err_q;
  assign o_err_code  = err_code_q;

endmodule

// File: tb/tb_dram_cmd_decoder.sv
// tb/tb_dram_cmd_decoder.sv - self-checking bench for dram_cmd_decoder

module tb_dram_cmd_decoder;
`ifdef DRAM_CMD_DEC_TIMING_CHECK_EN
  localparam bit TE = 1'b1;
`else
  localparam bit TE = 1'b0;
`endif

  localparam logic [2:0] P_MRS = 3'b000, P_REF = 3'b001, P_PRE = 3'b010, P_ACT = 3'b011,
                         P_WR  = 3'b100, P_RD  = 3'b101, P_ZQ  = 3'b110, P_NOP = 3'b111;

  logic        clk1 = 1'b0;
  logic        rst;
  logic        cke, cs_n, ras_n, cas_n, we_n;
  logic [2:0]  ba;
  logic [13:0] addr;
  logic        o_cmd_valid;
  logic [3:0]  o_cmd;
  logic [2:0]  o_ba;
  logic [13:0] o_row;
  logic [8:0]  o_col;
  logic [15:0] o_mr0, o_mr1, o_mr2, o_mr3;
  logic [7:0]  o_bank_open;
  logic        o_rd_window, o_wr_window, o_err;
  logic [2:0]  o_err_code;

  int errors = 0;
  int checks = 0;

  always #5 clk1 = ~clk1;

  dram_cmd_decoder dut (
    .clk1(clk1), .rst(rst), .cke(cke), .cs_n(cs_n), .ras_n(ras_n), .cas_n(cas_n),
    .we_n(we_n), .ba(ba), .addr(addr), .o_cmd_valid(o_cmd_valid), .o_cmd(o_cmd),
    .o_ba(o_ba), .o_row(o_row), .o_col(o_col), .o_mr0(o_mr0), .o_mr1(o_mr1),
    .o_mr2(o_mr2), .o_mr3(o_mr3), .o_bank_open(o_bank_open),
    .o_rd_window(o_rd_window), .o_wr_window(o_wr_window), .o_err(o_err),
    .o_err_code(o_err_code)
  );

  typedef struct {
    logic        cke;
    logic        cs_n;
    logic [2:0]  pins;
    logic [2:0]  ba;
    logic [13:0] addr;
    logic        exp_valid;
    logic [3:0]  exp_cmd;
    logic [2:0]  exp_ba;
    logic [13:0] exp_row;
    logic [8:0]  exp_col;
    logic [7:0]  exp_open;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the sampling posedge.
  task automatic drive(input logic c_cke, input logic c_cs_n, input logic [2:0] p,
                       input logic [2:0] b, input logic [13:0] a);
    cke = c_cke; cs_n = c_cs_n; {ras_n, cas_n, we_n} = p; ba = b; addr = a;
    @(posedge clk1);
    @(negedge clk1);
  endtask

  task automatic nop();
    drive(1'b1, 1'b0, P_NOP, 3'd0, 14'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cke = 1'b1; cs_n = 1'b1; {ras_n, cas_n, we_n} = P_NOP; ba = '0; addr = '0;
    repeat (2) begin
      @(posedge clk1);
      @(negedge clk1);
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    cke = 1'b1; cs_n = 1'b1; {ras_n, cas_n, we_n} = P_NOP; ba = '0; addr = '0;

    //            cke   cs_n  pins   ba    addr       v     cmd    ba    row        col      open
    vecs[0]  = '{1'b1, 1'b0, P_MRS, 3'd1, 14'h0ABC, 1'b1, 4'd1,  3'd1, 14'h0000, 9'h000, 8'h00};
    vecs[1]  = '{1'b1, 1'b0, P_MRS, 3'd3, 14'h3FFF, 1'b1, 4'd1,  3'd3, 14'h0000, 9'h000, 8'h00};
    vecs[2]  = '{1'b1, 1'b0, P_ZQ,  3'd0, 14'h0400, 1'b1, 4'd2,  3'd0, 14'h0000, 9'h000, 8'h00};
    vecs[3]  = '{1'b1, 1'b0, P_ZQ,  3'd0, 14'h0000, 1'b1, 4'd3,  3'd0, 14'h0000, 9'h000, 8'h00};
    vecs[4]  = '{1'b1, 1'b0, P_REF, 3'd0, 14'h0000, 1'b1, 4'd11, 3'd0, 14'h0000, 9'h000, 8'h00};
    vecs[5]  = '{1'b1, 1'b1, P_ACT, 3'd2, 14'h0155, 1'b0, 4'd0,  3'd0, 14'h0000, 9'h000, 8'h00};
    vecs[6]  = '{1'b0, 1'b0, P_ACT, 3'd2, 14'h0155, 1'b0, 4'd0,  3'd0, 14'h0000, 9'h000, 8'h00};
    vecs[7]  = '{1'b1, 1'b0, P_NOP, 3'd2, 14'h0155, 1'b0, 4'd0,  3'd0, 14'h0000, 9'h000, 8'h00};
    vecs[8]  = '{1'b1, 1'b0, P_ACT, 3'd5, 14'h2ABC, 1'b1, 4'd4,  3'd5, 14'h2ABC, 9'h000, 8'h20};
    vecs[9]  = '{1'b1, 1'b0, P_NOP, 3'd0, 14'h0000, 1'b0, 4'd0,  3'd0, 14'h0000, 9'h000, 8'h20};
    vecs[10] = '{1'b1, 1'b0, P_NOP, 3'd0, 14'h0000, 1'b0, 4'd0,  3'd0, 14'h0000, 9'h000, 8'h20};
    vecs[11] = '{1'b1, 1'b0, P_NOP, 3'd0, 14'h0000, 1'b0, 4'd0,  3'd0, 14'h0000, 9'h000, 8'h20};
    vecs[12] = '{1'b1, 1'b0, P_WR,  3'd5, 14'h0012, 1'b1, 4'd6,  3'd5, 14'h2ABC, 9'h012, 8'h20};
    vecs[13] = '{1'b1, 1'b0, P_RD,  3'd5, 14'h01FF, 1'b1, 4'd5,  3'd5, 14'h2ABC, 9'h1FF, 8'h20};
    vecs[14] = '{1'b1, 1'b0, P_PRE, 3'd0, 14'h0400, 1'b1, 4'd10, 3'd0, 14'h0000, 9'h000, 8'h00};
    vecs[15] = '{1'b1, 1'b0, P_PRE, 3'd5, 14'h0000, 1'b1, 4'd9,  3'd5, 14'h0000, 9'h000, 8'h00};

    @(negedge clk1);

    // Reset state, then MRS to MR0
    do_reset();
    check("reset_valid", o_cmd_valid, 0);
    check("reset_cmd", o_cmd, 0);
    check("reset_mr0", o_mr0, 0);
    check("reset_mr3", o_mr3, 0);
    check("reset_open", o_bank_open, 0);
    check("reset_rdwin", o_rd_window, 0);
    check("reset_wrwin", o_wr_window, 0);
    check("reset_err", o_err, 0);
    check("reset_code", o_err_code, 0);
    drive(1'b1, 1'b0, P_MRS, 3'd0, 14'h1D70);
    check("mrs_valid", o_cmd_valid, 1);
    check("mrs_cmd", o_cmd, 1);
    check("mrs_mr0", o_mr0, 16'h1D70);
    check("mrs_err", o_err, 0);

    // ACT bank 2, 4 NOPs, RD col 5: read window on cycles 7..10
    drive(1'b1, 1'b0, P_ACT, 3'd2, 14'h0123);
    repeat (4) nop();
    drive(1'b1, 1'b0, P_RD, 3'd2, 14'h0005);
    check("rd_cmd", o_cmd, 5);
    check("rd_open", o_bank_open, 8'h04);
    check("rd_row", o_row, 14'h0123);
    check("rd_col", o_col, 9'h005);
    check("rd_win_c1", o_rd_window, 0);
    for (int c = 2; c <= 12; c++) begin
      nop();
      check($sformatf("rd_win_c%0d", c), o_rd_window, (c >= 7 && c <= 10) ? 1 : 0);
    end
    check("rd_err", o_err, 0);

    // Two RDs 4 cycles apart: window high cycles 7..14 without a gap
    for (int c = 1; c <= 16; c++) begin
      if (c == 1 || c == 5) drive(1'b1, 1'b0, P_RD, 3'd2, 14'h0005);
      else nop();
      check($sformatf("b2b_win_c%0d", c), o_rd_window, (c >= 7 && c <= 14) ? 1 : 0);
    end

    // Deselect / cke low with ACT pins: nothing decoded, nothing changes
    drive(1'b1, 1'b1, P_ACT, 3'd2, 14'h0777);
    check("des_valid", o_cmd_valid, 0);
    check("des_open", o_bank_open, 8'h04);
    check("des_err", o_err, 0);
    drive(1'b0, 1'b0, P_ACT, 3'd3, 14'h0777);
    check("cke_valid", o_cmd_valid, 0);
    check("cke_open", o_bank_open, 8'h04);

    // ACT bank 0, then WRA col 0x1FF: bank closes, write window cycles 6..9
    drive(1'b1, 1'b0, P_ACT, 3'd0, 14'h0042);
    check("act0_open", o_bank_open, 8'h05);
    repeat (4) nop();
    drive(1'b1, 1'b0, P_WR, 3'd0, 14'h03FF);
    check("wra_cmd", o_cmd, 8);
    check("wra_col", o_col, 9'h1FF);
    check("wra_open", o_bank_open, 8'h04);
    check("wra_win_c1", o_wr_window, 0);
    for (int c = 2; c <= 11; c++) begin
      nop();
      check($sformatf("wra_win_c%0d", c), o_wr_window, (c >= 6 && c <= 9) ? 1 : 0);
    end
    check("wra_err", o_err, 0);

    // Table-driven decode sweep from a clean reset
    do_reset();
    foreach (vecs[i]) begin
      drive(vecs[i].cke, vecs[i].cs_n, vecs[i].pins, vecs[i].ba, vecs[i].addr);
      check($sformatf("vec%0d_valid", i), o_cmd_valid, vecs[i].exp_valid);
      check($sformatf("vec%0d_cmd", i), o_cmd, vecs[i].exp_cmd);
      check($sformatf("vec%0d_ba", i), o_ba, vecs[i].exp_ba);
      check($sformatf("vec%0d_row", i), o_row, vecs[i].exp_row);
      check($sformatf("vec%0d_col", i), o_col, vecs[i].exp_col);
      check($sformatf("vec%0d_open", i), o_bank_open, vecs[i].exp_open);
    end
    check("vec_mr1", o_mr1, 16'h0ABC);
    check("vec_mr3", o_mr3, 16'h3FFF);
    check("vec_err", o_err, 0);

    // tRCD: RD two cycles after ACT; later ACT to open bank keeps first code
    do_reset();
    drive(1'b1, 1'b0, P_ACT, 3'd1, 14'h0010);
    nop();
    drive(1'b1, 1'b0, P_RD, 3'd1, 14'h0000);
    check("trcd_err", o_err, TE);
    check("trcd_code", o_err_code, TE ? 3 : 0);
    nop();
    drive(1'b1, 1'b0, P_ACT, 3'd1, 14'h0020);
    check("trcd_act_err", o_err, 1);
    check("trcd_act_code", o_err_code, TE ? 3 : 1);
    check("trcd_act_valid", o_cmd_valid, 1);

    // tRP: ACT two cycles after PRE of the same bank
    do_reset();
    drive(1'b1, 1'b0, P_ACT, 3'd4, 14'h0001);
    repeat (3) nop();
    drive(1'b1, 1'b0, P_PRE, 3'd4, 14'h0000);
    check("trp_pre_open", o_bank_open, 8'h00);
    nop();
    drive(1'b1, 1'b0, P_ACT, 3'd4, 14'h0002);
    check("trp_err", o_err, TE);
    check("trp_code", o_err_code, TE ? 4 : 0);
    check("trp_open", o_bank_open, 8'h10);

    // Closed bank and tRCD together: lowest code reported
    do_reset();
    drive(1'b1, 1'b0, P_ACT, 3'd6, 14'h0003);
    drive(1'b1, 1'b0, P_PRE, 3'd6, 14'h0000);
    drive(1'b1, 1'b0, P_RD, 3'd6, 14'h0000);
    check("prio_err", o_err, 1);
    check("prio_code", o_err_code, 2);

    // REF with a bank open; later MRS still captured
    do_reset();
    drive(1'b1, 1'b0, P_ACT, 3'd0, 14'h0004);
    drive(1'b1, 1'b0, P_REF, 3'd0, 14'h0000);
    check("ref_code", o_err_code, 5);
    drive(1'b1, 1'b0, P_MRS, 3'd2, 14'h0042);
    check("ref_mr2", o_mr2, 16'h0042);
    check("ref_code_held", o_err_code, 5);

    // RD to closed bank 3, then async reset in the middle of its window
    do_reset();
    drive(1'b1, 1'b0, P_ACT, 3'd1, 14'h0005);
    drive(1'b1, 1'b0, P_RD, 3'd3, 14'h0000);
    check("closed_err", o_err, 1);
    check("closed_code", o_err_code, 2);
    check("closed_open", o_bank_open, 8'h02);
    for (int c = 2; c <= 8; c++) nop();
    check("closed_win", o_rd_window, 1);
    rst = 1'b1;
    #1;
    check("async_rdwin", o_rd_window, 0);
    check("async_err", o_err, 0);
    check("async_code", o_err_code, 0);
    check("async_open", o_bank_open, 0);
    @(negedge clk1);
    rst = 1'b0;
    nop();
    check("post_rst_win", o_rd_window, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
